input_debouncer: RTL and testbench

//   Cleans a raw asynchronous, bouncing level (push-button or switch) into a stable

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/bit_synchronizer.sv | 34 +++
 rtl/input_debouncer.sv | 122 ++++++++++++
 tb/tb_input_debouncer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared types and default constants for the input debouncer.
//                db_state_t encodes the four-state qualification FSM:
//                ST_LO / ST_HI are the stable levels, WT_HI / WT_LO are the
//                "candidate change being qualified" states.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO = 2'd0,
        WT_HI = 2'd1,
        ST_HI = 2'd2,
        WT_LO = 2'd3
    } db_state_t;

    localparam int DB_SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF      = 20;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_synchronizer
//  Description : Multi-flop synchronizer for a single asynchronous bit.
//                Output is the input delayed by STAGES clock edges.
//  Ports       : clk   - sampling clock, posedge
//                reset - asynchronous active-low reset, clears the chain to 0
//                d     - asynchronous input bit
//                q     - synchronized output bit
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule : bit_synchronizer
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Turns a raw, bouncing asynchronous level into a clean
//                synchronous level. The raw input passes through a
//                bit_synchronizer, then a four-state FSM accepts a level
//                change only after the synchronized value has held for
//                DB_CYCLES consecutive cycles beyond the first sighting.
//  Ports       : clk      - single clock, all flops on posedge
//                reset    - asynchronous active-low reset
//                in_raw   - raw asynchronous input level
//                db_level - registered debounced level
//                busy     - high while a candidate change is being qualified
//  Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DB_SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic db_level,
    output logic busy
);

    localparam int             CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    generate
        if ((DB_CYCLES < 2) || (SYNC_STAGES < 2)) begin : g_param_check
            $error("input_debouncer: DB_CYCLES and SYNC_STAGES must both be >= 2");
        end
    endgenerate

    logic             s_sync;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             db_level_next;

    // The only consumer of in_raw; everything downstream sees s_sync.
    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_raw),
        .q     (s_sync)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_LO;
            cnt      <= '0;
            db_level <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            db_level <= db_level_next;
        end
    end

    // A reversal while waiting drops straight back to the stable state with
    // the counter cleared, so qualification never accumulates across bounces.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        db_level_next = db_level;
        case (state)
            ST_LO: begin
                if (s_sync) begin
                    state_next = WT_HI;
                    cnt_next   = '0;
                end
            end
            WT_HI: begin
                if (!s_sync) begin
                    state_next = ST_LO;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next    = ST_HI;
                    cnt_next      = '0;
                    db_level_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_HI: begin
                if (!s_sync) begin
                    state_next = WT_LO;
                    cnt_next   = '0;
                end
            end
            WT_LO: begin
                if (s_sync) begin
                    state_next = ST_HI;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next    = ST_LO;
                    cnt_next      = '0;
                    db_level_next = 1'b0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next    = ST_LO;
                cnt_next      = '0;
                db_level_next = 1'b0;
            end
        endcase
    end

    // Decoded straight from the state register, so no combinational hazards.
    assign busy = (state == WT_HI) || (state == WT_LO);

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debouncer
//  Description : Self-checking bench for input_debouncer (DB_CYCLES=4,
//                SYNC_STAGES=2). The reference model tracks how many
//                consecutive synchronized samples have disagreed with the
//                current debounced level; DB_CYCLES+1 disagreeing samples in
//                a row flip the level.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic clk;
    logic reset;
    logic in_raw;
    logic db_level;
    logic busy;

    int checks;
    int failures;

    // Reference model state
    bit sq[$];
    bit m_db;
    int m_run;

    input_debouncer #(
        .SYNC_STAGES (SYNC),
        .DB_CYCLES   (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_raw   (in_raw),
        .db_level (db_level),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
        m_db  = 1'b0;
        m_run = 0;
    endtask

    // One active edge: the synchronized sample is the raw value seen SYNC
    // edges ago.
    task automatic model_edge(input bit raw);
        bit s;
        s = sq.pop_front();
        sq.push_back(raw);
        if (s != m_db) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_db  = s;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge(in_raw);
        #1;
        check("db_level", int'(db_level), int'(m_db));
        check("busy", int'(busy), (m_run != 0) ? 1 : 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called just after a tick: asserts reset between edges and checks that
    // the outputs clear without a clock edge.
    task automatic async_reset(input string tag, input int hold_edges);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check({tag, "_db_now"}, int'(db_level), 0);
        check({tag, "_busy_now"}, int'(busy), 0);
        ticks(hold_edges);
        reset = 1'b1;
    endtask

    // in_raw has just been changed; the next edge samples it. Returns how
    // many further edges pass until db_level equals target.
    task automatic measure(input bit target, output int n);
        tick();
        n = 0;
        while ((db_level !== target) && (n < 30)) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int busy_cnt;
        checks   = 0;
        failures = 0;
        in_raw   = 1'b1;
        reset    = 1'b1;
        model_reset();

        // 1: asynchronous reset with in_raw high
        #2;
        reset = 1'b0;
        #1;
        check("reset_db", int'(db_level), 0);
        check("reset_busy", int'(busy), 0);
        ticks(3);
        in_raw = 1'b0;
        ticks(2);
        reset = 1'b1;
        ticks(4);

        // 2: clean press, busy width and latency
        in_raw   = 1'b1;
        busy_cnt = 0;
        tick();
        n = 0;
        while ((db_level !== 1'b1) && (n < 30)) begin
            tick();
            n++;
            if (busy === 1'b1) busy_cnt++;
        end
        check("press_latency", n, 6);
        check("press_busy_cycles", busy_cnt, 4);
        ticks(4);

        // 5: release, then a 2-cycle high glitch during WT_LO
        in_raw = 1'b0;
        measure(1'b0, n);
        check("release_latency", n, 6);
        in_raw = 1'b1;
        ticks(10);
        in_raw = 1'b0;
        ticks(3);
        in_raw = 1'b1;
        ticks(2);
        in_raw = 1'b0;
        ticks(12);
        check("release_glitch_db", int'(db_level), 0);

        // 3: 3-cycle glitch rejected
        in_raw = 1'b1;
        ticks(3);
        in_raw = 1'b0;
        ticks(8);
        check("glitch_db", int'(db_level), 0);
        check("glitch_busy", int'(busy), 0);

        // 4: bounce then hold
        for (int i = 0; i < 4; i++) begin
            in_raw = (i % 2 == 0);
            tick();
        end
        check("bounce_db", int'(db_level), 0);
        in_raw = 1'b1;
        measure(1'b1, n);
        check("bounce_latency", n, 6);
        ticks(3);

        // Reset from ST_HI clears db_level immediately
        async_reset("rst_hi", 2);
        in_raw = 1'b0;
        ticks(6);

        // 6: reset while in WT_HI with cnt=2, in_raw kept high
        in_raw = 1'b1;
        ticks(5);
        check("midop_busy_before", int'(busy), 1);
        async_reset("midop", 2);
        measure(1'b1, n);
        check("midop_relatency", n, 6);
        ticks(3);

        // Randomized phases with occasional asynchronous resets
        for (int p = 0; p < 80; p++) begin
            in_raw = 1'($urandom_range(0, 1));
            ticks($urandom_range(1, 8));
            if ($urandom_range(0, 19) == 0) async_reset("rand_rst", $urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_input_debouncer
`default_nettype wire
